writeback_unit: RTL

Initiator side of the register-file write port: collects results from the ALU and from the load/memory path and issues at most one register write per cycle. Each write is driven as a write_register/write_data pair, where index 0 means no-op. Load results are buffered in a small in-order FIFO. A per-register busy mask lets issue/hazard logic stall on pending writes. Sits between execute/memory stages and the register file.

---
 rtl/writeback_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/writeback_unit.sv
// Register-file write initiator: ALU results take the write slot directly,
// load results queue in an in-order FIFO and drain into idle slots.
module writeback_unit #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REGISTERS = 32,
  parameter int QUEUE_DEPTH   = 4,
  localparam int REG_W        = $clog2(NUM_REGISTERS),
  localparam int CNT_W        = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  output logic                     alu_ready,
  input  logic [REG_W-1:0]         alu_rd,
  input  logic [DATA_WIDTH-1:0]    alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [REG_W-1:0]         mem_rd,
  input  logic [DATA_WIDTH-1:0]    mem_data,
  output logic [REG_W-1:0]         write_register,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [NUM_REGISTERS-1:0] busy_mask,
  output logic [CNT_W-1:0]         queue_count
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);

  typedef struct packed {
    logic [REG_W-1:0]      rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_entry_t;

  wb_entry_t              q [QUEUE_DEPTH];
  logic [PTR_W-1:0]       head, tail;
  logic [CNT_W-1:0]       count;
  logic [QUEUE_DEPTH-1:0] ent_vld, ent_hit;
  logic                   full, waw, alu_slot, pop, push;

  // Entry e is live when its distance from head is below the occupancy.
  for (genvar e = 0; e < QUEUE_DEPTH; e++) begin : g_ent
    logic [PTR_W-1:0] off;
    assign off        = PTR_W'(e) - head;
    assign ent_vld[e] = {1'b0, off} < count;
    assign ent_hit[e] = ent_vld[e] && (q[e].rd == alu_rd);
  end

  assign full        = (count == CNT_W'(QUEUE_DEPTH));
  // Hold a younger ALU write while an older load to the same register waits.
  assign waw         = (alu_rd != '0) && (|ent_hit);
  assign mem_ready   = !full;
  assign alu_ready   = !full && !waw;
  assign alu_slot    = alu_valid && alu_ready && (alu_rd != '0);
  assign pop         = !alu_slot && (count != '0);
  assign push        = mem_valid && mem_ready && (mem_rd != '0);
  assign queue_count = count;

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      if (push) begin
        q[tail] <= '{rd: mem_rd, data: mem_data};
        tail    <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (alu_slot) begin
        write_register <= alu_rd;
        write_data     <= alu_data;
      end else if (pop) begin
        write_register <= q[head].rd;
        write_data     <= q[head].data;
      end else begin
        write_register <= '0;
      end
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int e = 0; e < QUEUE_DEPTH; e++)
      if (ent_vld[e]) busy_mask[q[e].rd] = 1'b1;
    busy_mask[write_register] = 1'b1;
    busy_mask[0] = 1'b0;
  end
endmodule
